// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response and ALU-side signals of the two-port ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
);
    logic             r0_req_valid, r1_req_valid;
    logic             r0_req_ready, r1_req_ready;
    logic [WIDTH-1:0] r0_rs1, r0_rs2, r1_rs1, r1_rs2;
    logic [3:0]       r0_control, r1_control;
    logic [TAGW-1:0]  r0_tag, r1_tag;
    logic             r0_rsp_valid, r1_rsp_valid;
    logic             r0_rsp_ready, r1_rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero, rsp_carry, rsp_overflow, rsp_illegal;
    logic [TAGW-1:0]  rsp_tag;
    logic [WIDTH-1:0] alu_rs1, alu_rs2;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_rd;
    logic             alu_carry, alu_overflow;
    logic             busy;

    modport slave (
        input  r0_req_valid, r1_req_valid, r0_rs1, r0_rs2, r1_rs1, r1_rs2,
        input  r0_control, r1_control, r0_tag, r1_tag, r0_rsp_ready, r1_rsp_ready,
        input  alu_rd, alu_carry, alu_overflow,
        output r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
        output rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_illegal, rsp_tag,
        output alu_rs1, alu_rs2, alu_control, busy
    );

    modport master (
        output r0_req_valid, r1_req_valid, r0_rs1, r0_rs2, r1_rs1, r1_rs2,
        output r0_control, r1_control, r0_tag, r1_tag, r0_rsp_ready, r1_rsp_ready,
        output alu_rd, alu_carry, alu_overflow,
        input  r0_req_ready, r1_req_ready, r0_rsp_valid, r1_rsp_valid,
        input  rsp_result, rsp_zero, rsp_carry, rsp_overflow, rsp_illegal, rsp_tag,
        input  alu_rs1, alu_rs2, alu_control, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int TAGW  = 4
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state, next_state;
    logic             last_grant, grant_id;
    logic             win0, win1, rsp_ack, illegal, flag_op;
    logic [WIDTH-1:0] rs1_q, rs2_q;
    logic [3:0]       ctl_q;
    logic [TAGW-1:0]  tag_q;

    assign bus.r0_req_ready = !reset && state == IDLE && win0;
    assign bus.r1_req_ready = !reset && state == IDLE && win1;
    assign bus.r0_rsp_valid = state == RESP && !grant_id;
    assign bus.r1_rsp_valid = state == RESP && grant_id;
    assign bus.busy         = state != IDLE;
    assign bus.alu_rs1      = rs1_q;
    assign bus.alu_rs2      = rs2_q;
    assign bus.alu_control  = ctl_q;

    // Arbitration (the port that did not win last time takes a tie) and next state
    always_comb begin
        win0       = bus.r0_req_valid && (!bus.r1_req_valid || last_grant);
        win1       = bus.r1_req_valid && (!bus.r0_req_valid || !last_grant);
        rsp_ack    = grant_id ? bus.r1_rsp_ready : bus.r0_rsp_ready;
        illegal    = ctl_q > 4'd9;
        flag_op    = ctl_q == 4'b0010 || ctl_q == 4'b0110;
        next_state = state;
        case (state)
            IDLE:    next_state = (win0 || win1) ? ISSUE : IDLE;
            ISSUE:   next_state = RESP;
            RESP:    next_state = rsp_ack ? IDLE : RESP;
            default: next_state = IDLE;
        endcase
    end

    // State register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && (win0 || win1)) begin
                last_grant <= win1;
                grant_id   <= win1;
            end
        end
    end

    // Latch the winning request on grant; the ALU inputs hold it until the next grant
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_q <= '0;
            rs2_q <= '0;
            ctl_q <= '0;
            tag_q <= '0;
        end else if (state == IDLE && (win0 || win1)) begin
            rs1_q <= win1 ? bus.r1_rs1 : bus.r0_rs1;
            rs2_q <= win1 ? bus.r1_rs2 : bus.r0_rs2;
            ctl_q <= win1 ? bus.r1_control : bus.r0_control;
            tag_q <= win1 ? bus.r1_tag : bus.r0_tag;
        end
    end

    // Capture the ALU outcome at the end of ISSUE; carry/overflow only mean something for ADD/SUB
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_result   <= '0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_carry    <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_illegal  <= 1'b0;
            bus.rsp_tag      <= '0;
        end else if (state == ISSUE) begin
            bus.rsp_result   <= illegal ? '0 : bus.alu_rd;
            bus.rsp_zero     <= illegal || bus.alu_rd == '0;
            bus.rsp_carry    <= flag_op && bus.alu_carry;
            bus.rsp_overflow <= flag_op && bus.alu_overflow;
            bus.rsp_illegal  <= illegal;
            bus.rsp_tag      <= tag_q;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized scoreboard bench for the two-port ALU arbiter
module tb_alu_arbiter;
    localparam int W = 64;
    localparam int T = 4;

    typedef struct packed {logic [3:0] op; logic [63:0] a; logic [63:0] b; logic [3:0] tag;} req_t;
    typedef struct packed {logic [63:0] r; logic c; logic v;} alu_out_t;
    typedef struct {int port; logic [63:0] res; logic z; logic c; logic v; logic ill; logic [3:0] tag; int gcyc; bit seen;} exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W), .TAGW(T)) bus();
    alu_arbiter #(.WIDTH(W), .TAGW(T)) dut (.clk(clk), .reset(reset), .bus(bus));

    req_t     pend0[$], pend1[$];
    exp_t     exp_q[$];
    int       compared = 0, mismatched = 0, cyc = 0, last_accept = -1;
    int       ref_last = 1, hold1 = 0;
    bit       rsp_rand = 1'b0, junk_force = 1'b0;
    logic     junk = 1'b0;
    alu_out_t alu_o;

    function automatic alu_out_t ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        alu_out_t o;
        o = '0;
        case (op)
            4'd0: o.r = a & b;
            4'd1: o.r = a | b;
            4'd2: begin
                {o.c, o.r} = {1'b0, a} + {1'b0, b};
                o.v = (a[63] == b[63]) && (o.r[63] != a[63]);
            end
            4'd3: o.r = a ^ b;
            4'd4: o.r = a << b[5:0];
            4'd5: o.r = a >> b[5:0];
            4'd6: begin
                o.r = a - b;
                o.c = a < b;
                o.v = (a[63] != b[63]) && (o.r[63] != a[63]);
            end
            4'd7: o.r = $signed(a) >>> b[5:0];
            4'd8: o.r = {63'b0, $signed(a) < $signed(b)};
            4'd9: o.r = {63'b0, a < b};
            default: o.r = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
        return o;
    endfunction

    function automatic exp_t expect_of(input req_t q, input int port, input int gcyc);
        exp_t e;
        alu_out_t o;
        o = ref_alu(q.op, q.a, q.b);
        e.port = port;
        e.tag  = q.tag;
        e.gcyc = gcyc;
        e.seen = 1'b0;
        e.ill  = q.op > 4'd9;
        e.res  = e.ill ? 64'd0 : o.r;
        e.z    = e.res == 64'd0;
        e.c    = (q.op == 4'd2 || q.op == 4'd6) && o.c;
        e.v    = (q.op == 4'd2 || q.op == 4'd6) && o.v;
        return e;
    endfunction

    function automatic req_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        req_t q;
        q.op = op; q.a = a; q.b = b; q.tag = tag;
        return q;
    endfunction

    function automatic logic [63:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 64'd0;
            1: return 64'($urandom_range(0, 70));
            2: return {32'hFFFF_FFFF, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic req_t rnd_req();
        return mk(4'($urandom_range(0, 15)), rnd_word(), rnd_word(), 4'($urandom_range(0, 15)));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ALU stand-in: flags and illegal-op results are garbage where the arbiter must mask them
    always_comb begin
        alu_o            = ref_alu(bus.alu_control, bus.alu_rs1, bus.alu_rs2);
        bus.alu_rd       = alu_o.r;
        bus.alu_carry    = (bus.alu_control == 4'd2 || bus.alu_control == 4'd6) ? alu_o.c : junk;
        bus.alu_overflow = (bus.alu_control == 4'd2 || bus.alu_control == 4'd6) ? alu_o.v : junk;
    end

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        junk <= junk_force | 1'($urandom_range(0, 1));
    end

    // Requester drivers: valid stays up while a request is pending; data is random otherwise
    initial begin
        req_t q;
        forever begin
            @(posedge clk);
            #1;
            q = pend0.size() > 0 ? pend0[0] : rnd_req();
            bus.r0_req_valid = pend0.size() > 0;
            {bus.r0_control, bus.r0_rs1, bus.r0_rs2, bus.r0_tag} = q;
            q = pend1.size() > 0 ? pend1[0] : rnd_req();
            bus.r1_req_valid = pend1.size() > 0;
            {bus.r1_control, bus.r1_rs1, bus.r1_rs2, bus.r1_tag} = q;
            bus.r0_rsp_ready = rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.r1_rsp_ready = hold1 > 0 ? 1'b0 : (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (bus.r1_rsp_valid && hold1 > 0) hold1--;
        end
    end

    // Monitor: record grants into the scoreboard, compare every response cycle
    always @(negedge clk) begin
        if (!reset) begin
            chk("single_grant", 64'(bus.r0_req_ready && bus.r1_req_ready), 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (p == 0 ? bus.r0_req_ready : bus.r1_req_ready) begin
                    chk("grant_while_busy", 64'(bus.busy), 64'd0);
                    chk("grant_before_accept", 64'(cyc > last_accept), 64'd1);
                    chk("grant_with_outstanding", 64'(exp_q.size()), 64'd0);
                    if (bus.r0_req_valid && bus.r1_req_valid)
                        chk("rr_order", 64'(p), 64'(ref_last == 0));
                    ref_last = p;
                    if ((p == 0 ? pend0.size() : pend1.size()) == 0)
                        chk("grant_without_request", 64'd1, 64'd0);
                    else if (p == 0)
                        exp_q.push_back(expect_of(pend0.pop_front(), 0, cyc));
                    else
                        exp_q.push_back(expect_of(pend1.pop_front(), 1, cyc));
                end
            end
            chk("single_rsp", 64'(bus.r0_rsp_valid && bus.r1_rsp_valid), 64'd0);
            if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
                if (exp_q.size() == 0)
                    chk("spurious_rsp", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = exp_q[0];
                    chk("rsp_port", 64'(bus.r1_rsp_valid), 64'(e.port));
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_zero", 64'(bus.rsp_zero), 64'(e.z));
                    chk("rsp_carry", 64'(bus.rsp_carry), 64'(e.c));
                    chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(e.v));
                    chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
                    chk("rsp_tag", 64'(bus.rsp_tag), 64'(e.tag));
                    if (!e.seen) chk("rsp_latency", 64'(cyc - e.gcyc), 64'd2);
                    exp_q[0].seen = 1'b1;
                    if (bus.r1_rsp_valid ? bus.r1_rsp_ready : bus.r0_rsp_ready) begin
                        void'(exp_q.pop_front());
                        last_accept = cyc;
                    end
                end
            end
        end
    end

    task automatic zero_check(input string name);
        chk({name, "_ctl"}, 64'({bus.busy, bus.r0_req_ready, bus.r1_req_ready, bus.r0_rsp_valid, bus.r1_rsp_valid,
                                 bus.rsp_zero, bus.rsp_carry, bus.rsp_overflow, bus.rsp_illegal, bus.rsp_tag, bus.alu_control}), 64'd0);
        chk({name, "_result"}, bus.rsp_result, 64'd0);
        chk({name, "_alu_rs1"}, bus.alu_rs1, 64'd0);
        chk({name, "_alu_rs2"}, bus.alu_rs2, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (pend0.size() + pend1.size() + exp_q.size()) > 0; i++) @(negedge clk);
        if ((pend0.size() + pend1.size() + exp_q.size()) > 0) chk("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bit got;
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_check("reset");
        @(posedge clk); #2 reset = 1'b0;

        // contention straight out of reset: grants must go 0,1,0,1
        for (int i = 0; i < 2; i++) begin
            pend0.push_back(mk(4'd6, 64'd10, 64'd10, 4'(i)));
            pend1.push_back(mk(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'(8 + i)));
        end
        drain();

        pend0.push_back(mk(4'd2, 64'd5, 64'd7, 4'd3));
        drain();
        pend0.push_back(mk(4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd4));
        drain();
        junk_force = 1'b1;
        pend0.push_back(mk(4'd3, 64'hF0F0, 64'h0FF0, 4'd5));
        drain();
        junk_force = 1'b0;

        // backpressure on port 1 while port 0 waits
        hold1 = 5;
        pend1.push_back(mk(4'd1, 64'h1234, 64'h8000_0000_0000_0000, 4'd9));
        pend0.push_back(mk(4'd0, 64'hFF, 64'h0F, 4'd6));
        drain();

        pend0.push_back(mk(4'd12, 64'd3, 64'd4, 4'd7));
        pend0.push_back(mk(4'd0, 64'd3, 64'd6, 4'd8));
        drain();

        // reset while the port 1 request sits in ISSUE
        pend1.push_back(mk(4'd2, 64'd100, 64'd1, 4'd2));
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = bus.r1_req_ready;
        end
        chk("midop_grant_seen", 64'(got), 64'd1);
        @(posedge clk); #2 reset = 1'b1;
        exp_q.delete();
        ref_last = 1;
        @(negedge clk);
        @(negedge clk);
        zero_check("midop_reset");
        @(posedge clk); #2 reset = 1'b0;
        pend1.push_back(mk(4'd5, 64'hF00, 64'd4, 4'd1));
        pend0.push_back(mk(4'd7, 64'h8000_0000_0000_0000, 64'd63, 4'd0));
        drain();

        rsp_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) pend0.push_back(rnd_req());
            else pend1.push_back(rnd_req());
            repeat ($urandom_range(0, 4)) @(posedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
